// File: rtl/keypad_entry_scanner_if.sv
// Keypad/display-side signal bundle for keypad_entry_scanner.
// KEYPAD_LAST_KEY_EN adds key_code/key_strobe.
interface keypad_entry_scanner_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [12:0] num;
  logic [12:0] entered_num;
  logic        entered_valid;
  logic        overflow;
`ifdef KEYPAD_LAST_KEY_EN
  logic [3:0]  key_code;
  logic        key_strobe;

  modport slave  (input row, output col, num, entered_num, entered_valid, overflow, key_code, key_strobe);
  modport master (output row, input col, num, entered_num, entered_valid, overflow, key_code, key_strobe);
`else
  modport slave  (input row, output col, num, entered_num, entered_valid, overflow);
  modport master (output row, input col, num, entered_num, entered_valid, overflow);
`endif
endinterface

// File: rtl/keypad_entry_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, decimal entry with commit on '#'.
// Optional last-key outputs enabled by defining KEYPAD_LAST_KEY_EN.
module keypad_entry_scanner #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  keypad_entry_scanner_if.slave   kp
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned NUM_W   = 13;
  localparam int unsigned SUM_W   = 17;

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_ACT, ST_RELEASE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [3:0]         col_q, col_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [NUM_W-1:0]   entered_num_q, entered_num_d;
  logic               entered_valid_q, entered_valid_d;
  logic               overflow_q, overflow_d;
  logic [3:0]         row_s1_q, rs_q;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_strobe_q, key_strobe_d;

  logic [3:0]         key_c;
  logic [3:0]         digit_c;
  logic [SUM_W-1:0]   sum_c;
  logic [3:0]         row_pat_c;
  logic [1:0]         row_enc_c;

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      rs_q     <= 4'hF;
    end else begin
      row_s1_q <= kp.row;
      rs_q     <= row_s1_q;
    end
  end

  assign key_c     = {row_idx_q, col_idx_q};
  assign digit_c   = (key_c == 4'd13) ? 4'd0 : 4'(row_idx_q) * 4'd3 + 4'(col_idx_q) + 4'd1;
  assign sum_c     = SUM_W'(num_q) * SUM_W'(10) + SUM_W'(digit_c);
  assign row_pat_c = ~(4'b0001 << row_idx_q);

  always_comb begin
    row_enc_c = 2'd0;
    case (~rs_q)
      4'b0010: row_enc_c = 2'd1;
      4'b0100: row_enc_c = 2'd2;
      4'b1000: row_enc_c = 2'd3;
      default: row_enc_c = 2'd0;
    endcase
  end

  // Next-state and action logic
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    col_idx_d       = col_idx_q;
    row_idx_d       = row_idx_q;
    num_d           = num_q;
    entered_num_d   = entered_num_q;
    entered_valid_d = 1'b0;
    overflow_d      = 1'b0;
    key_code_d      = key_code_q;
    key_strobe_d    = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
          cnt_d = '0;
          // Ghosting (several rows low) is treated like no key
          if ($onehot(~rs_q)) begin
            row_idx_d = row_enc_c;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (rs_q == row_pat_c) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
            cnt_d   = '0;
            state_d = ST_ACT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ST_SCAN;
        end
      end
      ST_ACT: begin
        key_code_d   = key_c;
        key_strobe_d = 1'b1;
        case (key_c)
          4'd3:  num_d = num_q / NUM_W'(10);
          4'd12: num_d = '0;
          4'd14: begin
            entered_num_d   = num_q;
            entered_valid_d = 1'b1;
          end
          4'd7, 4'd11, 4'd15: ;
          default: begin
            if (sum_c <= SUM_W'(8191)) num_d = NUM_W'(sum_c);
            else                       overflow_d = 1'b1;
          end
        endcase
        cnt_d   = '0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rs_q == 4'hF) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SCAN;
      end
    endcase

    col_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_SCAN;
      cnt_q           <= '0;
      col_idx_q       <= 2'd0;
      row_idx_q       <= 2'd0;
      col_q           <= 4'b1110;
      num_q           <= '0;
      entered_num_q   <= '0;
      entered_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
      key_code_q      <= 4'd0;
      key_strobe_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      col_idx_q       <= col_idx_d;
      row_idx_q       <= row_idx_d;
      col_q           <= col_d;
      num_q           <= num_d;
      entered_num_q   <= entered_num_d;
      entered_valid_q <= entered_valid_d;
      overflow_q      <= overflow_d;
      key_code_q      <= key_code_d;
      key_strobe_q    <= key_strobe_d;
    end
  end

  assign kp.col           = col_q;
  assign kp.num           = num_q;
  assign kp.entered_num   = entered_num_q;
  assign kp.entered_valid = entered_valid_q;
  assign kp.overflow      = overflow_q;
`ifdef KEYPAD_LAST_KEY_EN
  assign kp.key_code      = key_code_q;
  assign kp.key_strobe    = key_strobe_q;
`endif

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Randomized self-checking bench for keypad_entry_scanner with a key-level model of number entry.
module tb_keypad_entry_scanner;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 8;

  logic clk;
  logic rst_n;
  int   held_key;
  logic [3:0] row_c;

  int n_tests;
  int n_fail;
  int ev_seen, ov_seen, ks_seen, col_bad;
  int m_num, m_ent;
  string keymap;

  keypad_entry_scanner_if kp();

  keypad_entry_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven
  always_comb begin
    row_c = 4'hF;
    if (held_key >= 0 && kp.col[held_key % 4] == 1'b0) row_c[held_key / 4] = 1'b0;
  end
  assign kp.row = row_c;

  always @(negedge clk) begin
    if (rst_n) begin
      if (kp.entered_valid) ev_seen++;
      if (kp.overflow)      ov_seen++;
`ifdef KEYPAD_LAST_KEY_EN
      if (kp.key_strobe)    ks_seen++;
`endif
      if (!$onehot(~kp.col)) col_bad++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int digit_key(input int d);
    return (d == 0) ? 13 : ((d - 1) / 3) * 4 + (d - 1) % 3;
  endfunction

  // Reference: apply one accepted key to the model, return expected pulse counts
  task automatic model_apply(input int k, output int exp_ev, output int exp_ov);
    byte ch;
    int  v;
    ch = keymap[k];
    exp_ev = 0;
    exp_ov = 0;
    if (ch >= 8'd48 && ch <= 8'd57) begin
      v = m_num * 10 + int'(ch - 8'd48);
      if (v <= 8191) m_num = v;
      else exp_ov = 1;
    end else if (ch == "A") begin
      m_num = m_num / 10;
    end else if (ch == "*") begin
      m_num = 0;
    end else if (ch == "#") begin
      m_ent = m_num;
      exp_ev = 1;
    end
  endtask

  task automatic press(input int k, input int hold);
    int ev0, ov0, ks0, e_ev, e_ov;
    ev0 = ev_seen; ov0 = ov_seen; ks0 = ks_seen;
    held_key = k;
    repeat (hold) @(negedge clk);
    held_key = -1;
    repeat (30) @(negedge clk);
    model_apply(k, e_ev, e_ov);
    check("num", int'(kp.num), m_num);
    check("entered_num", int'(kp.entered_num), m_ent);
    check("valid_pulses", ev_seen - ev0, e_ev);
    check("overflow_pulses", ov_seen - ov0, e_ov);
`ifdef KEYPAD_LAST_KEY_EN
    check("key_strobes", ks_seen - ks0, 1);
    check("key_code", int'(kp.key_code), k);
`else
    ks0 = ks0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, run, found, ev0, ov0;
    n_tests = 0; n_fail = 0;
    ev_seen = 0; ov_seen = 0; ks_seen = 0; col_bad = 0;
    m_num = 0; m_ent = 0;
    keymap = "123A456B789C*0#D";
    held_key = -1;
    rst_n = 1'b0;

    #23;
    check("rst_col", int'(kp.col), 4'hE);
    check("rst_num", int'(kp.num), 0);
    check("rst_entered", int'(kp.entered_num), 0);
    check("rst_valid", int'(kp.entered_valid), 0);
    check("rst_overflow", int'(kp.overflow), 0);

    // Idle rotation: each column held SCAN_DIV cycles, starting at column 0
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      check("idle_col", int'(kp.col), int'(~(4'b0001 << (((i + 1) / SCAN_DIV) % 4))) & 15);
    end
    check("idle_num", int'(kp.num), 0);
    check("idle_pulses", ev_seen + ov_seen, 0);

    // Digits then commit
    for (int d = 1; d <= 4; d++) press(digit_key(d), 40);
    press(14, 40);

    // Overflow boundary around 8191
    press(12, 40);
    press(digit_key(8), 40);
    press(digit_key(1), 40);
    press(digit_key(9), 40);
    press(digit_key(3), 40);
    press(digit_key(2), 40);
    press(digit_key(1), 40);
    press(14, 40);

    // Bouncing '1' on column 0 produces nothing; a stable press then counts once
    press(12, 40);
    ev0 = ev_seen; ov0 = ov_seen;
    for (int i = 0; i < 10; i++) begin
      held_key = (i % 2 == 0) ? 0 : -1;
      repeat (3) @(negedge clk);
    end
    held_key = -1;
    repeat (20) @(negedge clk);
    check("bounce_num", int'(kp.num), m_num);
    press(0, 40);

    // Long hold acts once; backspace; clear
    press(12, 40);
    press(digit_key(5), 200);
    press(3, 40);
    press(digit_key(7), 40);
    press(12, 40);
    press(7, 40);
    press(11, 40);
    press(15, 40);

    // Randomized key sequence
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 99) < 70) k = digit_key(int'($urandom_range(0, 9)));
      else k = int'($urandom_range(0, 15));
      press(k, int'($urandom_range(35, 60)));
    end

    // Reset while a press is being debounced
    press(12, 40);
    press(digit_key(4), 40);
    press(digit_key(2), 40);
    held_key = 0;
    run = 0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (kp.col == 4'b1110) run++;
      else run = 0;
      if (run == SCAN_DIV + 2) found = 1;
    end
    check("debounce_reached", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_col", int'(kp.col), 4'hE);
    check("midrst_num", int'(kp.num), 0);
    check("midrst_entered", int'(kp.entered_num), 0);
    held_key = -1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    ev0 = ev_seen; ov0 = ov_seen;
    repeat (60) @(negedge clk);
    m_num = 0; m_ent = 0;
    check("postrst_num", int'(kp.num), m_num);
    check("postrst_pulses", (ev_seen - ev0) + (ov_seen - ov0), 0);

    check("col_one_low", col_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
